univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised universal shift register; successor to the plain parallel-in/parallel-out register.
- Adds command-driven load, clear, logical shifts and rotates by a programmable step count. Execution is one bit-position per cycle under a small FSM.
- Serial in/out taps at both ends support chaining and serialisation in datapath blocks.

Parameters:
- W, 8, register width in bits (>=2).
- RESET_VAL, 0, value of q after reset (W bits).
- AW, $clog2(W+1), localparam: width of cmd_amt.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high in IDLE)
- cmd_op  in  3  operation code (see Behaviour)
- cmd_amt  in  AW  step count for shift/rotate ops
- cmd_data  in  W  parallel load data
- sin_l  in  1  serial input entering bit 0 on left shift
- sin_r  in  1  serial input entering bit W-1 on right shift
- q  out  W  register contents
- sout_l  out  1  q[W-1], combinational from q
- sout_r  out  1  q[0], combinational from q
- busy  out  1  high in BUSY state
- done  out  1  one-cycle registered completion pulse

Behaviour:
- Reset (clk edge with reset=0): q=RESET_VAL, state=IDLE, cnt=0, done=0, busy=0, cmd_ready=1. Reset mid-BUSY aborts the command; no done pulse is produced.
- Op codes: 0 NOP, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 CLR, 7 ASR (optional; see feature).
- Accept: cmd_valid & cmd_ready at a rising edge. cmd_ready = (state==IDLE). Inputs are ignored when not accepted.
- NOP / LOAD / CLR / shift-or-rotate with cmd_amt==0:
  - Complete at the accept edge. LOAD sets q=cmd_data; CLR sets q=0; the others leave q unchanged.
  - done=1 in the following cycle; state stays IDLE.
  - Back-to-back accepts are allowed every cycle.
- Shift/rotate with cmd_amt>=1:
  - At the accept edge: latch op, cnt=cmd_amt, state=BUSY; q is unchanged.
  - Each BUSY edge performs one step and cnt decrements.
  - On the step with cnt==1: state returns to IDLE and done=1 the next cycle.
  - Net effect: the final q is present amt edges after accept; done and cmd_ready rise together.
- Step definitions:
  - SHL: q={q[W-2:0],sin_l}
  - SHR: q={sin_r,q[W-1:1]}
  - ROL: q={q[W-2:0],q[W-1]}
  - ROR: q={q[0],q[W-1:1]}
  - sin_l/sin_r are sampled at each step edge, not at accept.
- cmd_amt > W: steps are executed literally. A shift then fills the whole register from the serial input; a rotate wraps modulo W naturally.
- done: high exactly one cycle per completed command; never high in reset or while busy.
- busy = (state==BUSY).
- FSM states: IDLE, BUSY. There is no other state.

Optional Feature:
- Macro: UNIV_SHIFT_REG_ASR_EN.
- Defined: op 7 = arithmetic shift right, q={q[W-1],q[W-1:1]}. It is multi-cycle exactly like SHR; sin_r is ignored.
- Undefined: op 7 decodes as NOP (single-cycle, done pulse, q unchanged).

Decomposition:
- Package shift_reg_pkg holds:
  - the op-code localparams/enum (OP_NOP..OP_ASR);
  - the FSM state enum (ST_IDLE, ST_BUSY);
  - a width helper for AW.
- One natural sub-module: shift_reg_step, a combinational next-value unit (inputs q, op, sin_l, sin_r; output next q). It is shared by the FSM and reusable by sibling blocks.

Test Plan:
- Reset: hold reset=0 for 2 edges with RESET_VAL=8'hA5 -> q=8'hA5, done=0, busy=0, cmd_ready=1. Assert reset during a SHL amt=5 after 2 steps -> q=8'hA5, IDLE, no done.
- LOAD 8'h3C then CLR on consecutive cycles -> q=8'h3C after the first edge, 8'h00 after the second; done high two consecutive cycles; busy never high.
- LOAD 8'h81, then ROL amt=3 -> busy for 3 cycles, q=8'h0C, done one cycle after the final step. Then ROR amt=3 -> q=8'h81.
- LOAD 8'hF0, SHR amt=4 with sin_r=0,1,0,1 on successive step edges -> q=8'hAF; sout_r tracks q[0] each cycle.
- SHL amt=0 and cmd_valid held during BUSY -> amt=0 completes in IDLE with q unchanged and done pulse. The command held during BUSY is accepted only at the edge where cmd_ready=1.
- Op 7 on q=8'h90, amt=2: with UNIV_SHIFT_REG_ASR_EN -> q=8'hE4; without it -> q=8'h90, single-cycle done.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared op codes, FSM states and helpers for the universal shift register.
// Optional feature macro: UNIV_SHIFT_REG_ASR_EN (op 7 becomes arithmetic shift right).
package shift_reg_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_CLR  = 3'd6,
        OP_ASR  = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Width needed to hold a step count of 0..w inclusive.
    function automatic int amt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // True for ops that run one bit-position per cycle. Op 7 only counts
    // when the arithmetic shift is built in; otherwise it behaves as NOP.
    function automatic logic is_step_op(input op_e op);
`ifdef UNIV_SHIFT_REG_ASR_EN
        return op inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR};
`else
        return op inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR};
`endif
    endfunction

endpackage

// File: rtl/shift_reg_step.sv
// shift_reg_step: combinational single-step next value for shift/rotate ops.
// Ports: q (current value), op, sin_l (enters bit 0 on SHL), sin_r (enters bit W-1 on SHR),
//        nxt (value after one step; q unchanged for non-step ops).
// Optional feature macro: UNIV_SHIFT_REG_ASR_EN.
module shift_reg_step
    import shift_reg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] q,
    input  op_e          op,
    input  logic         sin_l,
    input  logic         sin_r,
    output logic [W-1:0] nxt
);

    logic [W-1:0] asr_v;

`ifdef UNIV_SHIFT_REG_ASR_EN
    assign asr_v = {q[W-1], q[W-1:1]};
`else
    assign asr_v = q;
`endif

    always_comb begin
        nxt = op == OP_SHL ? {q[W-2:0], sin_l} :
              op == OP_SHR ? {sin_r, q[W-1:1]} :
              op == OP_ROL ? {q[W-2:0], q[W-1]} :
              op == OP_ROR ? {q[0], q[W-1:1]} :
              op == OP_ASR ? asr_v : q;
    end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with command-driven load/clear/shift/rotate.
// Ports: clk, reset (sync, active-low); cmd_valid/cmd_ready handshake with cmd_op,
//        cmd_amt (step count), cmd_data (load value); sin_l/sin_r serial inputs;
//        q contents, sout_l = q[W-1], sout_r = q[0]; busy while stepping; done pulse.
// Optional feature macro: UNIV_SHIFT_REG_ASR_EN (op 7 = arithmetic shift right).
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int W = 8,
    parameter logic [W-1:0] RESET_VAL = '0,
    localparam int AW = amt_width(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_amt,
    input  logic [W-1:0]  cmd_data,
    input  logic          sin_l,
    input  logic          sin_r,
    output logic [W-1:0]  q,
    output logic          sout_l,
    output logic          sout_r,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  q_q, q_d, step_q;
    logic          done_q, done_d;
    op_e           cmd_op_e;
    logic          accept;

    assign cmd_op_e = op_e'(cmd_op);
    assign accept   = cmd_valid && state_q == ST_IDLE;

    shift_reg_step #(.W(W)) u_step (
        .q     (q_q),
        .op    (op_q),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .nxt   (step_q)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        done_d  = 1'b0;
        if (state_q == ST_BUSY) begin
            q_d   = step_q;
            cnt_d = cnt_q - AW'(1);
            // Last step: hand back to IDLE so done and cmd_ready rise together.
            if (cnt_q == AW'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if (accept) begin
            if (is_step_op(cmd_op_e) && cmd_amt != '0) begin
                state_d = ST_BUSY;
                op_d    = cmd_op_e;
                cnt_d   = cmd_amt;
            end else begin
                q_d    = cmd_op_e == OP_LOAD ? cmd_data :
                         cmd_op_e == OP_CLR  ? '0 : q_q;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
            q_q     <= RESET_VAL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign q         = q_q;
    assign sout_l    = q_q[W-1];
    assign sout_r    = q_q[0];
    assign busy      = state_q == ST_BUSY;
    assign cmd_ready = state_q == ST_IDLE;
    assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: table-driven and randomized checks of univ_shift_reg against a behavioural model.
module tb_univ_shift_reg;

`ifdef UNIV_SHIFT_REG_ASR_EN
    localparam bit ASR_EN = 1'b1;
`else
    localparam bit ASR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_amt = '0;
    logic [7:0] cmd_data = '0;
    logic       sin_l = 1'b0;
    logic       sin_r = 1'b0;
    logic [7:0] q;
    logic       sout_l, sout_r, busy, done;

    int checks = 0;
    int failures = 0;
    logic [7:0] cur;

    univ_shift_reg #(.W(8), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
        .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l), .sout_r(sout_r),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [2:0]  op;
        int          amt;
        logic [7:0]  d;
        logic [15:0] pl;
        logic [15:0] pr;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic bit multi_op(input logic [2:0] op, input int amt);
        return amt != 0 && (op inside {3'd2, 3'd3, 3'd4, 3'd5} || (op == 3'd7 && ASR_EN));
    endfunction

    // Result after n steps: shifts treat the register as a window over a bit stream,
    // rotates are a slice of the value doubled up.
    function automatic logic [7:0] model(input logic [2:0] op, input int n, input logic [7:0] q0,
                                         input logic [15:0] pl, input logic [15:0] pr, input logic [7:0] d);
        bit b[$];
        logic [15:0] dd;
        logic [7:0] r;
        int k;
        k = n % 8;
        dd = {q0, q0};
        r = q0;
        case (op)
            3'd1: r = d;
            3'd6: r = 8'h00;
            3'd2: begin
                for (int i = 7; i >= 0; i--) b.push_back(q0[i]);
                for (int i = 0; i < n; i++) b.push_back(pl[i]);
                for (int j = 0; j < 8; j++) r[j] = b[b.size() - 1 - j];
            end
            3'd3, 3'd7: begin
                if (op == 3'd3 || ASR_EN) begin
                    for (int i = 7; i >= 0; i--) b.push_back(q0[i]);
                    for (int i = 0; i < n; i++) b.push_front(op == 3'd7 ? q0[7] : pr[i]);
                    for (int j = 0; j < 8; j++) r[7 - j] = b[j];
                end
            end
            3'd4: begin dd = dd << k; r = dd[15:8]; end
            3'd5: begin dd = dd >> k; r = dd[7:0]; end
            default: r = q0;
        endcase
        return r;
    endfunction

    // Issue one command from IDLE at a negedge and follow it to the end of its done pulse.
    task automatic do_cmd(input string nm, input logic [2:0] op, input int amt, input logic [7:0] d,
                          input logic [15:0] pl, input logic [15:0] pr, input logic [7:0] exp);
        logic [7:0] st, mid;
        st = cur;
        chk({nm, " ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt[3:0]; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_amt = 4'($urandom); cmd_data = 8'($urandom);
        if (multi_op(op, amt)) begin
            for (int i = 0; i < amt; i++) begin
                mid = model(op, i, st, pl, pr, d);
                chk({nm, " busy"}, busy, 1);
                chk({nm, " done_mid"}, done, 0);
                chk({nm, " ready_mid"}, cmd_ready, 0);
                chk({nm, " q_mid"}, q, mid);
                chk({nm, " sout_l"}, sout_l, mid[7]);
                chk({nm, " sout_r"}, sout_r, mid[0]);
                sin_l = pl[i]; sin_r = pr[i];
                @(negedge clk);
            end
        end
        chk({nm, " done"}, done, 1);
        chk({nm, " busy_end"}, busy, 0);
        chk({nm, " q"}, q, exp);
        chk({nm, " sout_l_end"}, sout_l, exp[7]);
        chk({nm, " sout_r_end"}, sout_r, exp[0]);
        cur = exp;
        @(negedge clk);
        chk({nm, " done_off"}, done, 0);
    endtask

    initial begin
        logic [2:0] rop;
        int ramt;
        logic [7:0] rd, rexp;
        logic [15:0] rpl, rpr;

        tbl[0]  = '{"load81",  3'd1, 0,  8'h81, 16'h0000, 16'h0000, 8'h81};
        tbl[1]  = '{"rol3",    3'd4, 3,  8'h00, 16'h0000, 16'h0000, 8'h0C};
        tbl[2]  = '{"ror3",    3'd5, 3,  8'h00, 16'h0000, 16'h0000, 8'h81};
        tbl[3]  = '{"loadf0",  3'd1, 0,  8'hF0, 16'h0000, 16'h0000, 8'hF0};
        tbl[4]  = '{"shr4",    3'd3, 4,  8'h00, 16'hFFFF, 16'h000A, 8'hAF};
        tbl[5]  = '{"load90",  3'd1, 0,  8'h90, 16'h0000, 16'h0000, 8'h90};
        tbl[6]  = '{"op7",     3'd7, 2,  8'h00, 16'h0000, 16'h0000, ASR_EN ? 8'hE4 : 8'h90};
        tbl[7]  = '{"shl0",    3'd2, 0,  8'h00, 16'hFFFF, 16'hFFFF, ASR_EN ? 8'hE4 : 8'h90};
        tbl[8]  = '{"load01",  3'd1, 0,  8'h01, 16'h0000, 16'h0000, 8'h01};
        tbl[9]  = '{"shl10",   3'd2, 10, 8'h00, 16'hFFFF, 16'h0000, 8'hFF};
        tbl[10] = '{"load5a",  3'd1, 0,  8'h5A, 16'h0000, 16'h0000, 8'h5A};
        tbl[11] = '{"rol8",    3'd4, 8,  8'h00, 16'h0000, 16'h0000, 8'h5A};
        tbl[12] = '{"nop3",    3'd0, 3,  8'h00, 16'h0000, 16'h0000, 8'h5A};
        tbl[13] = '{"clr",     3'd6, 0,  8'h33, 16'h0000, 16'h0000, 8'h00};

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        chk("rst q", q, 8'hA5);
        chk("rst done", done, 0);
        chk("rst busy", busy, 0);
        chk("rst ready", cmd_ready, 1);
        reset = 1'b1;
        cur = 8'hA5;
        @(negedge clk);

        foreach (tbl[i]) do_cmd(tbl[i].nm, tbl[i].op, tbl[i].amt, tbl[i].d, tbl[i].pl, tbl[i].pr, tbl[i].exp);

        // LOAD then CLR back-to-back.
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 8'h3C; cmd_amt = 4'd0;
        @(negedge clk);
        chk("b2b q_load", q, 8'h3C);
        chk("b2b done1", done, 1);
        chk("b2b busy1", busy, 0);
        cmd_op = 3'd6;
        @(negedge clk);
        chk("b2b q_clr", q, 8'h00);
        chk("b2b done2", done, 1);
        chk("b2b busy2", busy, 0);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b done_off", done, 0);
        cur = 8'h00;

        // Command held valid during BUSY is taken only once IDLE returns.
        do_cmd("hold_load", 3'd1, 0, 8'h81, 16'h0, 16'h0, 8'h81);
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_amt = 4'd2;
        @(negedge clk);
        cmd_op = 3'd2; cmd_amt = 4'd0;
        for (int i = 0; i < 2; i++) begin
            chk("hold busy", busy, 1);
            chk("hold ready", cmd_ready, 0);
            chk("hold q_mid", q, model(3'd4, i, 8'h81, 16'h0, 16'h0, 8'h0));
            @(negedge clk);
        end
        chk("hold rol_done", done, 1);
        chk("hold rol_q", q, 8'h06);
        chk("hold ready_end", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("hold shl0_done", done, 1);
        chk("hold shl0_busy", busy, 0);
        chk("hold shl0_q", q, 8'h06);
        @(negedge clk);
        chk("hold done_off", done, 0);
        cur = 8'h06;

        // Reset in the middle of a SHL amt=5 after two steps.
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_amt = 4'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) begin sin_l = 1'b1; @(negedge clk); end
        chk("abort busy_pre", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort q", q, 8'hA5);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort ready", cmd_ready, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort done_after", done, 0);
        chk("abort busy_after", busy, 0);
        cur = 8'hA5;

        // Randomized commands against the model.
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ramt = $urandom_range(0, 15);
            rd = 8'($urandom);
            rpl = 16'($urandom);
            rpr = 16'($urandom);
            rexp = model(rop, multi_op(rop, ramt) ? ramt : 0, cur, rpl, rpr, rd);
            do_cmd("rand", rop, ramt, rd, rpl, rpr, rexp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
